mdu_seq: RTL
============

// Module: mdu_seq
// PURPOSE
//  Multi-cycle sequencer for the M-extension ops decoded by the IDU (alu_op[16:12]: mul/div/divu/rem/remu, plus the W forms).
//  Accepts one request, iterates an internal shift-add / restoring-divide datapath, and applies sign and W fix-ups.
//  Returns one result pulse. The core stalls while req_valid && !resp_valid. Sits beside the ALU in EXU.
// PARAMETERS
//  WIDTH  64  datapath width (XLEN); W ops use the low 32 bits
// PORTS
//  clk         in   1      single clock, all state on posedge
//  rst         in   1      synchronous, active-low reset
//  req_valid   in   1      request present
//  req_ready   out  1      high only in IDLE; accept = req_valid & req_ready & one-hot op
//  req_op      in   5      one-hot {remu,rem,divu,div,mul} (= alu_op[16:12])
//  req_32bit   in   1      W-form op (IDU inst_32bit)
//  req_op1     in   WIDTH  dividend / multiplicand
//  req_op2     in   WIDTH  divisor / multiplier
//  flush       in   1      kill in-flight op (trap/redirect)
//  busy        out  1      state != IDLE
//  resp_valid  out  1      1-cycle pulse, result valid; no backpressure
//  resp_data   out  WIDTH  result, held until next DONE
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, counter=0, resp_data=0, resp_valid=0, busy=0, req_ready=1.
//  FSM IDLE->CALC->FIXUP->DONE->IDLE.
//  - IDLE: on accept, latch operands, N=req_32bit?32:64.
//    Special div cases go straight to FIXUP; otherwise go to CALC.
//  - CALC: exactly N cycles, one bit per cycle, counter N-1..0; at counter 0 go to FIXUP.
//  - FIXUP: 1 cycle; apply sign correction, select q/r/product, sign-extend bit31 for W, register resp_data.
//  - DONE: resp_valid=1 for this cycle only, req_ready=0; then IDLE.
//  Latency (accept cycle = 0): resp_valid in cycle N+2; special cases in cycle 2.
//  Operands:
//  - W signed ops sign-extend op[31:0]; W unsigned ops zero-extend op[31:0] (IDU zero-extends both).
//  - Signed div works on |a|,|b|. q negated iff signs differ; r takes the dividend's sign.
//  - MUL/MULW produce the low WIDTH / low 32 bits of the product (sign-agnostic).
//  Divide-by-zero: q=all ones; r=dividend (W: sext32). No iterations.
//  Signed overflow: dividend=-2^(N-1), divisor=-1 gives q=dividend, r=0 (W: sext32). No iterations.
//  Boundary rules:
//  - req_valid with a non-one-hot op (0 or >1 bits): ignored; no state change, no resp.
//  - req_valid held while busy: not accepted; re-accepted only after DONE->IDLE.
//  - flush in IDLE/CALC/FIXUP: next state IDLE, no resp_valid. flush in the accept cycle drops the request.
//  - flush in a DONE cycle: resp_valid still high that cycle, then IDLE.
//  - rst low in any state: immediate return to reset values at that edge; no resp.
// CONFIGURATION
//  MDU_FAST_MUL_EN
//  - defined: MUL/MULW use a single-cycle WIDTH x WIDTH multiply and go IDLE->FIXUP; latency 2.
//  - undefined: iterative shift-add in CALC, N cycles; latency N+2.
//  Divide is always iterative.
// STRUCTURE
//  mdu_pkg: state encoding (IDLE/CALC/FIXUP/DONE), op bit indices (MUL=0..REMU=4), iteration counts 64/32, counter width 7.
//  Sub-module mdu_div_step: combinational single restoring step, {rem,quo} + divisor -> next {rem,quo}.
//  Instanced once inside mdu_seq. FSM, counter, sign logic and mul path stay in mdu_seq.
// TESTING
//  1 DIV: op1=-7, op2=2 -> 0xFFFF_FFFF_FFFF_FFFD, resp_valid in cycle 66. REM same operands -> 0xFFFF_FFFF_FFFF_FFFF.
//  2 DIVU: op1=5, op2=0 -> 0xFFFF_FFFF_FFFF_FFFF in cycle 2. REMU -> 5. DIVW: 7/0 -> all ones.
//  3 DIVW: op1=0x8000_0000, op2=0xFFFF_FFFF, 32bit -> 0xFFFF_FFFF_8000_0000 in cycle 2. REMW -> 0.
//  4 MULW: op1=0x7FFF_FFFF, op2=2 -> 0xFFFF_FFFF_FFFF_FFFE, cycle 34 (cycle 2 with MDU_FAST_MUL_EN).
//    MUL: op1=-3, op2=5 -> 0xFFFF_FFFF_FFFF_FFF1.
//  5 Flush at CALC cycle 10 of a DIVU -> no resp_valid; req_ready=1 next cycle. Following REMU 100%7 -> 2.
//  6 rst low mid-CALC -> reset values next edge. req_op=5'b00011 -> ignored, busy stays 0.
//    req_valid held through op -> exactly one resp_valid.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared FSM encoding, op indices and iteration constants for
//               the M-extension sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int OP_MUL  = 0;
    localparam int OP_DIV  = 1;
    localparam int OP_DIVU = 2;
    localparam int OP_REM  = 3;
    localparam int OP_REMU = 4;

    localparam int ITER_64 = 64;
    localparam int ITER_32 = 32;
    localparam int CNT_W   = 7;

    localparam logic [CNT_W-1:0] CNT_LOAD_64 = CNT_W'(ITER_64 - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD_32 = CNT_W'(ITER_32 - 1);

    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_div_step.sv
// ============================================================================
// Module      : mdu_div_step
// Description : One combinational restoring-divide step on a {rem,quo} pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_shifted = {rem_in, quo_in[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, divisor};
        // Bit WIDTH of the difference is set exactly when the trial subtract underflows.
        if (!w_diff[WIDTH]) begin
            rem_out = w_diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = w_shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================================
// Module      : mdu_seq
// Description : Multi-cycle MUL/DIV/REM sequencer (64-bit and W forms).
//               MDU_FAST_MUL_EN selects a single-cycle multiplier for MUL ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic             req_32bit,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    input  logic             flush,
    output logic             busy,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is32;
    logic             r_is_mul;
    logic             r_want_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_resp_data;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_signed;
    logic [WIDTH-1:0] w_ext1;
    logic [WIDTH-1:0] w_ext2;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_min;
    logic             w_div0;
    logic             w_ovf;
    logic             w_skip_calc;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_result;
`ifdef MDU_FAST_MUL_EN
    logic [WIDTH-1:0] w_fast_prod;
`endif

    // ------------------------------------------------------------------
    // Request decode and operand preparation
    // ------------------------------------------------------------------
    always_comb begin
        w_accept    = (r_state == S_IDLE) && req_valid && is_onehot5(req_op) && !flush;
        w_is_mul    = req_op[OP_MUL];
        w_is_signed = req_op[OP_DIV] | req_op[OP_REM];
        if (req_32bit) begin
            w_ext1 = w_is_signed ? {{(WIDTH-32){req_op1[31]}}, req_op1[31:0]}
                                 : {{(WIDTH-32){1'b0}}, req_op1[31:0]};
            w_ext2 = w_is_signed ? {{(WIDTH-32){req_op2[31]}}, req_op2[31:0]}
                                 : {{(WIDTH-32){1'b0}}, req_op2[31:0]};
            w_min  = {{(WIDTH-31){1'b1}}, 31'd0};
        end else begin
            w_ext1 = req_op1;
            w_ext2 = req_op2;
            w_min  = {1'b1, {(WIDTH-1){1'b0}}};
        end
        w_neg1 = w_is_signed & w_ext1[WIDTH-1];
        w_neg2 = w_is_signed & w_ext2[WIDTH-1];
        w_mag1 = w_neg1 ? -w_ext1 : w_ext1;
        w_mag2 = w_neg2 ? -w_ext2 : w_ext2;
        w_div0 = (w_ext2 == '0);
        w_ovf  = w_is_signed && (w_ext1 == w_min) && (&w_ext2);
`ifdef MDU_FAST_MUL_EN
        w_skip_calc = w_is_mul | w_div0 | w_ovf;
`else
        w_skip_calc = !w_is_mul && (w_div0 || w_ovf);
`endif
    end

`ifdef MDU_FAST_MUL_EN
    assign w_fast_prod = req_op1 * req_op2;
`endif

    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_div),
        .rem_out (w_step_rem),
        .quo_out (w_step_quo)
    );

    always_comb begin
        w_q_fix  = r_neg_q ? -r_quo : r_quo;
        w_r_fix  = r_neg_r ? -r_rem : r_rem;
        w_sel    = r_is_mul ? r_rem : (r_want_rem ? w_r_fix : w_q_fix);
        w_result = r_is32 ? {{(WIDTH-32){w_sel[31]}}, w_sel[31:0]} : w_sel;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        busy         = 1'b1;
        resp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept) begin
                    w_next_state = w_skip_calc ? S_FIXUP : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next_state = S_FIXUP;
                end
            end
            S_FIXUP: w_next_state = S_DONE;
            S_DONE: begin
                resp_valid   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (flush) begin
            w_next_state = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, iteration, fix-up
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_is32      <= 1'b0;
            r_is_mul    <= 1'b0;
            r_want_rem  <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_resp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is32     <= req_32bit;
                        r_is_mul   <= w_is_mul;
                        r_want_rem <= req_op[OP_REM] | req_op[OP_REMU];
                        r_cnt      <= req_32bit ? CNT_LOAD_32 : CNT_LOAD_64;
                        r_neg_q    <= 1'b0;
                        r_neg_r    <= 1'b0;
                        r_div      <= w_mag2;
                        if (w_is_mul) begin
`ifdef MDU_FAST_MUL_EN
                            r_rem <= w_fast_prod;
`else
                            r_rem <= '0;
`endif
                            r_quo <= req_op1;
                            r_div <= req_op2;
                        end else if (w_div0) begin
                            r_quo <= '1;
                            r_rem <= w_ext1;
                        end else if (w_ovf) begin
                            r_quo <= w_ext1;
                            r_rem <= '0;
                        end else begin
                            // W dividends start in the upper half so the first 32 shifts feed the remainder.
                            r_rem   <= '0;
                            r_quo   <= req_32bit ? (w_mag1 << 32) : w_mag1;
                            r_neg_q <= w_neg1 ^ w_neg2;
                            r_neg_r <= w_neg1;
                        end
                    end
                end
                S_CALC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                    if (r_is_mul) begin
                        r_rem <= r_rem + (r_div[0] ? r_quo : '0);
                        r_quo <= r_quo << 1;
                        r_div <= r_div >> 1;
                    end else begin
                        r_rem <= w_step_rem;
                        r_quo <= w_step_quo;
                    end
                end
                S_FIXUP: begin
                    if (!flush) begin
                        r_resp_data <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_data = r_resp_data;

endmodule

`default_nettype wire
